histogram_loader: RTL

//  Restores one histogram slot from the SD card into histogram RAM. Reads SECTORS consecutive
//  512-byte sectors starting at byte address slot<<SLOT_SHIFT through the shared SD controller.

---
 rtl/histogram_loader_pkg.sv | 27 ++
 rtl/sd_byte_pairer.sv | 73 +++++++
 rtl/histogram_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/histogram_loader_pkg.sv
// histogram_loader_pkg: SD/histogram constants shared by loader and saver,
// loader state encoding and byte-half select.
package histogram_loader_pkg;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int HIST_SLOT_SHIFT = 11;
  localparam int HIST_WORDS      = 1024;

  localparam int HIST_AW = $clog2(HIST_WORDS);
  localparam int BCW     = $clog2(SD_SECTOR_BYTES) + 1;

  localparam logic [BCW-1:0] SECTOR_BYTES =
    BCW'(SD_SECTOR_BYTES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    RECV      = 2'd3
  } ld_state_t;

  typedef enum logic {
    MS = 1'b0,
    LS = 1'b1
  } half_t;

endpackage

// File: rtl/sd_byte_pairer.sv
// sd_byte_pairer: takes SD bytes on byte_available rising edges and
// packs them MS-first into 16-bit RAM words.
module sd_byte_pairer
  import histogram_loader_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           clear,
  input  logic           sd_byte_available,
  input  logic [7:0]     sd_dout,
  output logic [BCW-1:0] byte_cnt_nxt,
  output logic           pair_take,
  output logic           we,
  output logic [15:0]    wdata
);

  logic           last_avail;
  logic           byte_ev;
  logic           take;
  half_t          half;
  logic [7:0]     ms_reg;
  logic [BCW-1:0] byte_cnt;

  assign byte_ev = sd_byte_available & ~last_avail;

  // bytes beyond a full sector are dropped
  assign take = enable & byte_ev &
                (byte_cnt != SECTOR_BYTES);

  assign pair_take    = take & (half == LS);
  assign byte_cnt_nxt = byte_cnt + BCW'(take);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_avail <= 1'b0;
    end else begin
      last_avail <= sd_byte_available;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half     <= MS;
      byte_cnt <= '0;
      ms_reg   <= '0;
    end else if (clear) begin
      half     <= MS;
      byte_cnt <= '0;
    end else if (take) begin
      byte_cnt <= byte_cnt_nxt;
      if (half == MS) begin
        ms_reg <= sd_dout;
        half   <= LS;
      end else begin
        half   <= MS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      wdata <= '0;
    end else begin
      we <= pair_take;
      if (pair_take) begin
        wdata <= {ms_reg, sd_dout};
      end
    end
  end

endmodule

// File: rtl/histogram_loader.sv
// histogram_loader: restores one histogram slot from SD card into
// histogram RAM port B, sector by sector.
module histogram_loader
  import histogram_loader_pkg::*;
#(
  parameter int SECTORS    = 4,
  parameter int SLOT_SHIFT = HIST_SLOT_SHIFT,
  parameter int TIMEOUT    = 2**24 - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         slot,
  input  logic               sd_ready,
  input  logic [7:0]         sd_dout,
  input  logic               sd_byte_available,
  output logic               sd_rd,
  output logic [31:0]        sd_address,
  output logic [HIST_AW-1:0] waddr,
  output logic [15:0]        wdata,
  output logic               we,
  output logic               loading,
  output logic               done,
  output logic               error
);

  localparam int SW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] LAST_SEC = SW'(SECTORS - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  ld_state_t      state;
  ld_state_t      state_nxt;
  logic [SW-1:0]  sector;
  logic [TW-1:0]  tmo;
  logic [BCW-1:0] byte_cnt_nxt;
  logic           pair_take;

  logic tmo_hit;
  logic acc_start;
  logic issue;
  logic busy_seen;
  logic tmo_fail;
  logic sec_end;
  logic sec_ok;
  logic fin;
  logic next_sec;
  logic short_fail;

  assign tmo_hit = (tmo == TMO_MAX);

  sd_byte_pairer u_pairer (
    .clk               (clk),
    .reset             (reset),
    .enable            (state == RECV),
    .clear             (issue),
    .sd_byte_available (sd_byte_available),
    .sd_dout           (sd_dout),
    .byte_cnt_nxt      (byte_cnt_nxt),
    .pair_take         (pair_take),
    .we                (we),
    .wdata             (wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (sd_ready)     state_nxt = WAIT_BUSY;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_BUSY: begin
        if (!sd_ready)    state_nxt = RECV;
        else if (tmo_hit) state_nxt = IDLE;
      end
      RECV: begin
        if (sd_ready) begin
          state_nxt = next_sec ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // completion looks at the count including a byte taken this cycle
  always_comb begin
    acc_start  = 1'b0;
    issue      = 1'b0;
    busy_seen  = 1'b0;
    tmo_fail   = 1'b0;
    sec_end    = 1'b0;
    sec_ok     = 1'b0;
    fin        = 1'b0;
    next_sec   = 1'b0;
    short_fail = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        acc_start = start;
      end
      (state == ISSUE): begin
        issue    = sd_ready;
        tmo_fail = ~sd_ready & tmo_hit;
      end
      (state == WAIT_BUSY): begin
        busy_seen = ~sd_ready;
        tmo_fail  = sd_ready & tmo_hit;
      end
      (state == RECV): begin
        sec_end    = sd_ready;
        sec_ok     = sec_end &
                     (byte_cnt_nxt == SECTOR_BYTES);
        fin        = sec_ok & (sector == LAST_SEC);
        next_sec   = sec_ok & (sector != LAST_SEC);
        short_fail = sec_end & ~sec_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_rd      <= 1'b0;
      sd_address <= '0;
      sector     <= '0;
      loading    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= fin;
      if (acc_start) begin
        sd_address <= 32'(slot) << SLOT_SHIFT;
        sector     <= '0;
        error      <= 1'b0;
        loading    <= 1'b1;
      end
      if (issue) begin
        sd_rd <= 1'b1;
      end
      if (busy_seen | tmo_fail) begin
        sd_rd <= 1'b0;
      end
      if (tmo_fail | short_fail) begin
        error   <= 1'b1;
        loading <= 1'b0;
      end
      if (fin) begin
        loading <= 1'b0;
      end
      if (next_sec) begin
        sector     <= sector + 1'b1;
        sd_address <= sd_address +
                      32'(SD_SECTOR_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo <= '0;
    end else if (state_nxt != state) begin
      tmo <= '0;
    end else if (state == ISSUE ||
                 state == WAIT_BUSY) begin
      tmo <= tmo + 1'b1;
    end
  end

  // an in-flight final write steps waddr onto the next sector itself
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr <= '0;
    end else if (acc_start) begin
      waddr <= '0;
    end else if (we) begin
      waddr <= waddr + 1'b1;
    end else if (next_sec && !pair_take) begin
      waddr <= HIST_AW'((int'(sector) + 1) << 8);
    end
  end

endmodule
